hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 140 ++++++++++++++
 tb/tb_hilo_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences MULT/DIV through an external iterative
// engine, serves MFHI/MFLO/MTHI/MTLO, and flags engine timeouts.
module hilo_ctrl #(
    parameter logic [5:0] TIMEOUT = 6'd63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        eng_start,
    output logic        eng_sel,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        eng_done,
    input  logic [31:0] eng_hi,
    input  logic [31:0] eng_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MULT = 3'd1,
        OP_DIV  = 3'd2,
        OP_MFHI = 3'd3,
        OP_MFLO = 3'd4,
        OP_MTHI = 3'd5,
        OP_MTLO = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    state_t     state;
    op_t        op_dec;
    logic [5:0] wait_cnt;
    logic       eng_start_q;
    logic       accept;

    assign op_dec = op_t'(op);
    assign stall  = op_valid & (state != IDLE);
    assign accept = op_valid & ~stall & ~flush;

    // The start pulse is registered for the ISSUE cycle; a flush arriving in
    // that same cycle must still cancel it, hence the combinational gate.
    assign eng_start = eng_start_q & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            eng_start_q <= 1'b0;
            eng_sel     <= 1'b0;
            eng_a       <= '0;
            eng_b       <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            hi          <= '0;
            lo          <= '0;
            err         <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            rd_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op_dec)
                            OP_MULT: begin
                                eng_a       <= rs_data;
                                eng_b       <= rt_data;
                                eng_sel     <= 1'b0;
                                eng_start_q <= 1'b1;
                                state       <= ISSUE;
                            end
                            OP_DIV: begin
                                if (rt_data != '0) begin
                                    eng_a       <= rs_data;
                                    eng_b       <= rt_data;
                                    eng_sel     <= 1'b1;
                                    eng_start_q <= 1'b1;
                                    state       <= ISSUE;
                                end else begin
                                    hi <= rs_data;
                                    lo <= '1;
                                end
                            end
                            OP_MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Flush outranks a simultaneous done: the result is dropped.
                    if (flush) begin
                        state <= IDLE;
                    end else if (eng_done) begin
                        hi    <= eng_hi;
                        lo    <= eng_lo;
                        state <= IDLE;
                    end else if (wait_cnt == TIMEOUT - 6'd1) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl with a hand-driven engine model.
module tb_hilo_ctrl;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] MULT = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] MFHI = 3'd3;
    localparam logic [2:0] MFLO = 3'd4;
    localparam logic [2:0] MTHI = 3'd5;
    localparam logic [2:0] MTLO = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        eng_start;
    logic        eng_sel;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        eng_done;
    logic [31:0] eng_hi;
    logic [31:0] eng_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned start_seen;

    hilo_ctrl #(.TIMEOUT(6'd63)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .stall    (stall),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .eng_start(eng_start),
        .eng_sel  (eng_sel),
        .eng_a    (eng_a),
        .eng_b    (eng_b),
        .eng_done (eng_done),
        .eng_hi   (eng_hi),
        .eng_lo   (eng_lo),
        .hi       (hi),
        .lo       (lo),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = NOP; rs_data = '0; rt_data = '0;
        flush = 1'b0; eng_done = 1'b0; eng_hi = '0; eng_lo = '0;
        tick(); tick();
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_start", {31'd0, eng_start}, 32'd0);
        rst = 1'b0;
        tick();

        // MULT 7 * -3, then MFLO stalled behind it
        present(MULT, 32'd7, 32'hFFFF_FFFD);
        check("mult_nostall", {31'd0, stall}, 32'd0);
        tick();
        check("mult_start", {31'd0, eng_start}, 32'd1);
        check("mult_a", eng_a, 32'd7);
        check("mult_b", eng_b, 32'hFFFF_FFFD);
        check("mult_sel", {31'd0, eng_sel}, 32'd0);
        present(MFLO, 32'd0, 32'd0);
        check("mflo_stall", {31'd0, stall}, 32'd1);
        tick();
        start_seen = 0;
        for (int i = 0; i < 32; i++) begin
            if (eng_start) start_seen++;
            tick();
        end
        check("mult_one_start", start_seen, 32'd0);
        check("mflo_stall_wait", {31'd0, stall}, 32'd1);
        eng_done = 1'b1; eng_hi = 32'hFFFF_FFFF; eng_lo = 32'hFFFF_FFEB;
        tick();
        eng_done = 1'b0;
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mflo_unstall", {31'd0, stall}, 32'd0);
        tick();
        op_valid = 1'b0;
        check("mflo_valid", {31'd0, rd_valid}, 32'd1);
        check("mflo_data", rd_data, 32'hFFFF_FFEB);
        tick();
        check("mflo_pulse", {31'd0, rd_valid}, 32'd0);

        // Divide by zero resolves locally
        present(DIV, 32'd100, 32'd0);
        tick();
        check("dz_nostart", {31'd0, eng_start}, 32'd0);
        check("dz_hi", hi, 32'd100);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        present(MFHI, 32'd0, 32'd0);
        check("dz_idle", {31'd0, stall}, 32'd0);
        tick();
        check("dz_mfhi", rd_data, 32'd100);
        present(MFLO, 32'd0, 32'd0);
        tick();
        op_valid = 1'b0;
        check("dz_mflo", rd_data, 32'hFFFF_FFFF);

        // Flush and done in the same cycle: result discarded
        present(MTLO, 32'd5, 32'd0);
        tick();
        check("mtlo", lo, 32'd5);
        present(DIV, 32'd9, 32'd2);
        tick();
        op_valid = 1'b0;
        check("div_sel", {31'd0, eng_sel}, 32'd1);
        check("div_start", {31'd0, eng_start}, 32'd1);
        tick(); tick();
        flush = 1'b1; eng_done = 1'b1; eng_hi = 32'd1; eng_lo = 32'd4;
        tick();
        flush = 1'b0; eng_done = 1'b0;
        check("fd_lo", lo, 32'd5);
        check("fd_hi", hi, 32'd100);
        present(NOP, 32'd0, 32'd0);
        check("fd_idle", {31'd0, stall}, 32'd0);

        // Flush in ISSUE suppresses the start pulse
        present(MULT, 32'd3, 32'd4);
        tick();
        op_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_issue_start", {31'd0, eng_start}, 32'd0);
        tick();
        flush = 1'b0;
        present(NOP, 32'd0, 32'd0);
        check("flush_issue_idle", {31'd0, stall}, 32'd0);

        // An op presented with flush in IDLE is ignored
        flush = 1'b1;
        present(MTHI, 32'h0000_0ABC, 32'd0);
        tick();
        flush = 1'b0; op_valid = 1'b0;
        check("flush_idle_op", hi, 32'd100);

        // Engine never finishes: timeout after 63 WAIT cycles
        present(MULT, 32'd1, 32'd1);
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 0; i < 62; i++) tick();
        check("to_not_yet", {31'd0, err}, 32'd0);
        tick();
        check("to_err", {31'd0, err}, 32'd1);
        check("to_hi", hi, 32'd100);
        check("to_lo", lo, 32'd5);
        present(MTHI, 32'h55, 32'd0);
        check("to_idle", {31'd0, stall}, 32'd0);
        tick();
        op_valid = 1'b0;
        check("to_mthi", hi, 32'h55);
        check("to_sticky", {31'd0, err}, 32'd1);

        // Reset while waiting on the engine
        present(MULT, 32'd6, 32'd7);
        tick();
        op_valid = 1'b0;
        tick(); tick();
        present(NOP, 32'd0, 32'd0);
        rst = 1'b1;
        #2;
        check("mr_hi", hi, 32'd0);
        check("mr_lo", lo, 32'd0);
        check("mr_err", {31'd0, err}, 32'd0);
        check("mr_a", eng_a, 32'd0);
        check("mr_b", eng_b, 32'd0);
        check("mr_rd", rd_data, 32'd0);
        check("mr_stall", {31'd0, stall}, 32'd0);
        op_valid = 1'b0;
        tick();
        rst = 1'b0;
        eng_done = 1'b1; eng_hi = 32'd42; eng_lo = 32'd43;
        tick();
        eng_done = 1'b0;
        tick();
        check("mr_hi_after", hi, 32'd0);
        check("mr_lo_after", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
